// File: rtl/carry_bypass_mp_sequencer.sv
// Multi-precision add/subtract sequencer driving an external WIDTH-bit adder one limb per cycle.
// Optional zero flag enabled by defining CBA_SEQ_ZERO_FLAG_EN; otherwise res_zero is tied 0.
module carry_bypass_mp_sequencer #(
    parameter int WIDTH = 16,
    parameter int LIMBS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             op_sub,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_last,
    output logic             res_cout,
    output logic             res_ovf,
    output logic             res_zero
);
    localparam int CNT_W = $clog2(LIMBS) + 1;
    localparam int MSB   = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             carry_q;
    logic             sub_q;
    logic [CNT_W-1:0] cnt;
    logic             start_hs_s;
    logic             in_hs_s;
    logic             res_accept_s;
    logic             last_limb_s;

    // Subtraction feeds the inverted B operand; the +1 comes from carry_q preset on start
    assign add_a   = a_in;
    assign add_b   = b_in ^ {WIDTH{sub_q}};
    assign add_cin = carry_q;

    // Ready signals depend only on state and output-register occupancy
    always_comb begin
        start_ready = 1'b0;
        in_ready    = 1'b0;
        case (state_r)
            IDLE:    start_ready = ~rst;
            RUN:     in_ready    = ~res_valid | res_ready;
            DRAIN:   in_ready    = 1'b0;
            default: begin
                start_ready = 1'b0;
                in_ready    = 1'b0;
            end
        endcase
    end

    assign start_hs_s   = start_valid & start_ready;
    assign in_hs_s      = in_valid & in_ready;
    assign res_accept_s = res_valid & res_ready;
    assign last_limb_s  = (cnt == CNT_W'(LIMBS - 1));

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_hs_s) state_next_s = RUN;
                else            state_next_s = IDLE;
            end
            RUN: begin
                if (in_hs_s && last_limb_s) state_next_s = DRAIN;
                else                        state_next_s = RUN;
            end
            DRAIN: begin
                if (res_accept_s) state_next_s = IDLE;
                else              state_next_s = DRAIN;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, carry chain, result register and end-of-operation flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            carry_q   <= 1'b0;
            sub_q     <= 1'b0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_last  <= 1'b0;
            res_cout  <= 1'b0;
            res_ovf   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                IDLE: begin
                    if (start_hs_s) begin
                        sub_q    <= op_sub;
                        carry_q  <= op_sub;
                        cnt      <= '0;
                        res_cout <= 1'b0;
                        res_ovf  <= 1'b0;
                    end
                end
                RUN: begin
                    if (in_hs_s) begin
                        res_sum   <= add_sum;
                        res_valid <= 1'b1;
                        carry_q   <= add_cout;
                        cnt       <= cnt + CNT_W'(1);
                        res_last  <= last_limb_s;
                        if (last_limb_s) begin
                            res_cout <= add_cout;
                            res_ovf  <= (a_in[MSB] == add_b[MSB]) && (add_sum[MSB] != a_in[MSB]);
                        end
                    end else if (res_accept_s) begin
                        res_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (res_accept_s) begin
                        res_valid <= 1'b0;
                        res_last  <= 1'b0;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    res_last  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CBA_SEQ_ZERO_FLAG_EN
    logic zero_acc_r;  // set once any result limb of the current operation is nonzero

    // Zero accumulator; res_zero is published together with the last limb
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_acc_r <= 1'b0;
            res_zero   <= 1'b0;
        end else if (start_hs_s) begin
            zero_acc_r <= 1'b0;
            res_zero   <= 1'b0;
        end else if (in_hs_s) begin
            zero_acc_r <= zero_acc_r | (|add_sum);
            if (last_limb_s) res_zero <= ~(zero_acc_r | (|add_sum));
        end
    end
`else
    assign res_zero = 1'b0;
`endif

endmodule

// File: tb/tb_carry_bypass_mp_sequencer.sv
// Self-checking bench for carry_bypass_mp_sequencer: models the external adder and
// compares every result limb and flag against full-width arithmetic.
module tb_carry_bypass_mp_sequencer;
    localparam int WIDTH = 16;
    localparam int LIMBS = 4;
    localparam int TOTW  = WIDTH * LIMBS;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic             op_sub = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_sum;
    logic             res_last;
    logic             res_cout;
    logic             res_ovf;
    logic             res_zero;

    int checks   = 0;
    int failures = 0;

    carry_bypass_mp_sequencer #(.WIDTH(WIDTH), .LIMBS(LIMBS)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready), .op_sub(op_sub),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_last(res_last), .res_cout(res_cout), .res_ovf(res_ovf), .res_zero(res_zero)
    );

    // External adder
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    always #5 clk = ~clk;

    // One full operation with random handshake pressure; returns cycles from start accept to final accept
    task automatic do_op(input logic [TOTW-1:0] a, input logic [TOTW-1:0] b, input logic sub,
                         input int rdy_pct, input int vld_pct, input int stall0,
                         output int run_cycles, output int start_wait);
        logic [TOTW:0]    full;
        logic [TOTW-1:0]  r;
        logic             exp_cout, exp_ovf, exp_zero;
        logic [WIDTH-1:0] exp_limb, hold_sum;
        logic             hold_pending, hold_last, exp_in_ready;
        int sent, got, cyc, stall_left;
        if (sub) begin
            r        = a - b;
            exp_cout = (a >= b);
            exp_ovf  = (a[TOTW-1] != b[TOTW-1]) && (r[TOTW-1] != a[TOTW-1]);
        end else begin
            full     = {1'b0, a} + {1'b0, b};
            r        = full[TOTW-1:0];
            exp_cout = full[TOTW];
            exp_ovf  = (a[TOTW-1] == b[TOTW-1]) && (r[TOTW-1] != a[TOTW-1]);
        end
`ifdef CBA_SEQ_ZERO_FLAG_EN
        exp_zero = (r == '0);
`else
        exp_zero = 1'b0;
`endif
        start_valid = 1'b1; op_sub = sub; in_valid = 1'b0; res_ready = 1'b0;
        start_wait = 0;
        @(negedge clk);
        while (!start_ready && start_wait < 20) begin
            @(posedge clk); #1; start_wait++;
            @(negedge clk);
        end
        checks++;
        if (!start_ready) begin
            failures++;
            $display("FAIL start_timeout: start_ready=%b required 1", start_ready);
        end
        @(posedge clk); #1;
        start_valid = 1'b0;
        checks++;
        if ({res_cout, res_ovf, res_zero} !== 3'b000) begin
            failures++;
            $display("FAIL flags_clear_on_start: got %b required 000", {res_cout, res_ovf, res_zero});
        end
        sent = 0; got = 0; cyc = 0; stall_left = stall0; hold_pending = 1'b0;
        hold_sum = '0; hold_last = 1'b0;
        while (got < LIMBS && cyc < 300) begin
            in_valid = (sent < LIMBS) && ($urandom_range(99) < vld_pct);
            if (sent < LIMBS) begin
                a_in = a[sent*WIDTH +: WIDTH];
                b_in = b[sent*WIDTH +: WIDTH];
            end
            res_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            exp_in_ready = (sent < LIMBS) && (!res_valid || res_ready);
            checks++;
            if (in_ready !== exp_in_ready) begin
                failures++;
                $display("FAIL in_ready: got %b required %b (sent=%0d)", in_ready, exp_in_ready, sent);
            end
            if (hold_pending) begin
                checks++;
                if (res_valid !== 1'b1 || res_sum !== hold_sum || res_last !== hold_last) begin
                    failures++;
                    $display("FAIL hold_stable: got v=%b sum=%h last=%b required v=1 sum=%h last=%b",
                             res_valid, res_sum, res_last, hold_sum, hold_last);
                end
            end
            if (stall_left > 0 && res_valid) begin
                checks++;
                if (in_ready !== 1'b0 || res_sum !== r[WIDTH-1:0]) begin
                    failures++;
                    $display("FAIL backpressure: got in_ready=%b sum=%h required 0 and %h",
                             in_ready, res_sum, r[WIDTH-1:0]);
                end
                stall_left--;
            end
            if (in_valid && in_ready) begin
                checks++;
                if (add_b !== (b_in ^ {WIDTH{sub}}) || (sent == 0 && add_cin !== sub)) begin
                    failures++;
                    $display("FAIL adder_drive: got add_b=%h cin=%b required add_b=%h (limb %0d)",
                             add_b, add_cin, b_in ^ {WIDTH{sub}}, sent);
                end
                sent++;
            end
            hold_pending = res_valid && !res_ready;
            hold_sum     = res_sum;
            hold_last    = res_last;
            if (res_valid && res_ready) begin
                exp_limb = r[got*WIDTH +: WIDTH];
                checks++;
                if (res_sum !== exp_limb || res_last !== (got == LIMBS - 1)) begin
                    failures++;
                    $display("FAIL limb%0d: got sum=%h last=%b required sum=%h last=%b",
                             got, res_sum, res_last, exp_limb, (got == LIMBS - 1));
                end
                if (got == LIMBS - 1) begin
                    checks++;
                    if (res_cout !== exp_cout || res_ovf !== exp_ovf || res_zero !== exp_zero) begin
                        failures++;
                        $display("FAIL final_flags: got cout=%b ovf=%b zero=%b required %b %b %b",
                                 res_cout, res_ovf, res_zero, exp_cout, exp_ovf, exp_zero);
                    end
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; res_ready = 1'b0;
        checks++;
        if (got < LIMBS) begin
            failures++;
            $display("FAIL op_timeout: got %0d limbs required %0d", got, LIMBS);
        end
        @(negedge clk);
        checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL back_to_idle: got start_ready=%b res_valid=%b required 1 0", start_ready, res_valid);
        end
        @(posedge clk); #1;
        run_cycles = cyc;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({start_ready, in_ready, res_valid, res_last, res_cout, res_ovf, res_zero} !== 7'b0
            || res_sum !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state: got rdy=%b inr=%b v=%b last=%b flags=%b%b%b sum=%h required all 0",
                     start_ready, in_ready, res_valid, res_last, res_cout, res_ovf, res_zero, res_sum);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (start_ready !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got start_ready=%b in_ready=%b required 1 0", start_ready, in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        int rc, sw;
        do_op(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 100, 100, 0, rc, sw);
        do_op(64'h0, 64'h1, 1'b1, 100, 100, 0, rc, sw);
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 100, 100, 0, rc, sw);
    endtask

    task automatic test_backpressure;
        int rc, sw;
        do_op(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 100, 100, 3, rc, sw);
        do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 30, 100, 2, rc, sw);
    endtask

    task automatic test_reset_mid_op;
        int rc, sw;
        start_valid = 1'b1; op_sub = 1'b0;
        @(posedge clk); #1;
        start_valid = 1'b0;
        in_valid = 1'b1; res_ready = 1'b1; a_in = 16'hFFFF; b_in = 16'h0001;
        @(posedge clk); #1;
        a_in = 16'hFFFF; b_in = 16'hFFFF;
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (start_ready !== 1'b0) begin
            failures++;
            $display("FAIL start_ready_in_reset: got %b required 0", start_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL res_valid_after_reset: got %b required 0", res_valid);
        end
        rst = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
                failures++;
                $display("FAIL idle_ignores_input: got res_valid=%b start_ready=%b required 0 1",
                         res_valid, start_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        do_op(64'h1, 64'h1, 1'b0, 100, 100, 0, rc, sw);
    endtask

    task automatic test_zero_flag;
        int rc, sw;
        do_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 100, 100, 0, rc, sw);
        do_op(64'h0, 64'h0, 1'b0, 70, 70, 0, rc, sw);
        do_op(64'h0001_0000_0000_0000, 64'h0, 1'b0, 100, 100, 0, rc, sw);
    endtask

    task automatic test_back_to_back;
        int rc, sw;
        for (int i = 0; i < 3; i++) begin
            do_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)), 100, 100, 0, rc, sw);
            checks++;
            if (rc !== LIMBS + 1 || sw !== 0) begin
                failures++;
                $display("FAIL throughput: got run=%0d wait=%0d required run=%0d wait=0", rc, sw, LIMBS + 1);
            end
        end
    endtask

    task automatic test_random;
        int rc, sw;
        logic [TOTW-1:0] a, b;
        for (int i = 0; i < 25; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 5 == 0) b = a;
            if (i % 7 == 0) a = {TOTW{1'b1}};
            do_op(a, b, 1'($urandom_range(1)), 60, 70, 0, rc, sw);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_zero_flag();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/carry_bypass_mp_sequencer.md
# carry_bypass_mp_sequencer

Multi-precision add/subtract sequencer that drives one external 16-bit carry-bypass adder limb by limb and chains its carry across cycles to produce LIMBS×WIDTH-bit results. It sits between a streaming operand source and a result consumer, with valid/ready handshakes on both sides. It owns the carry register, the operation state machine and the final status flags.

## Interface
- WIDTH, 16, limb width; must equal the attached adder width.
- LIMBS, 4, limbs per operation; legal range 2..16.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  request to begin an operation.
- start_ready  out  1  high only in IDLE; forced 0 while rst is high.
- op_sub  in  1  sampled on the start handshake; 1 = A−B, 0 = A+B.
- in_valid / in_ready  in/out  1  operand limb handshake, least significant limb first.
- a_in, b_in  in  WIDTH  operand limbs.
- add_a, add_b  out  WIDTH  to adder: add_a = a_in, add_b = b_in XOR {WIDTH{sub_q}}.
- add_cin  out  1  to adder: carry_q.
- add_sum  in  WIDTH  from adder.
- add_cout  in  1  from adder.
- res_valid / res_ready  out/in  1  result limb handshake.
- res_sum  out  WIDTH  registered result limb.
- res_last  out  1  qualifies the final limb.
- res_cout  out  1  final carry-out; for subtraction, 1 = no borrow. Valid with res_last.
- res_ovf  out  1  signed overflow of the full-width operation. Valid with res_last.
- res_zero  out  1  all result limbs zero (CBA_SEQ_ZERO_FLAG_EN only; otherwise tied 0).

## Operation
- States are IDLE, RUN and DRAIN. Reset enters IDLE.
- Registers reset to 0: res_valid, res_sum, res_last, res_cout, res_ovf, res_zero, carry_q, sub_q, cnt.
- IDLE:
  - start_ready = 1.
  - On start_valid: sub_q ← op_sub, carry_q ← op_sub (two's-complement +1), cnt ← 0, go to RUN.
- RUN:
  - in_ready = !res_valid || res_ready (single-entry output register).
  - On an input handshake:
    - res_sum ← add_sum, res_valid ← 1, carry_q ← add_cout, cnt ← cnt+1.
    - res_last ← (cnt == LIMBS−1).
  - On the final limb: res_cout ← add_cout, res_ovf ← (a_in[MSB] == add_b[MSB]) && (add_sum[MSB] != a_in[MSB]), go to DRAIN.
- DRAIN:
  - in_ready = 0.
  - When the last limb is accepted (res_valid && res_ready): res_valid ← 0, res_last ← 0, go to IDLE.
- Output handshake: res_valid clears on acceptance unless a new limb loads in the same cycle. Simultaneous accept and load means the register holds the new limb and res_valid stays 1.
- start_valid outside IDLE is ignored. in_valid outside RUN is ignored.
- While res_valid && !res_ready: res_sum, res_last and the flags hold stable.
- Reset mid-operation: the operation is discarded, no further res_valid is produced, and the carry is cleared.
- Status flags hold their values until the next start handshake, which clears them.

## Timing
- The adder path is combinational: a_in/b_in/carry_q → add_* → add_sum/add_cout feed the result register in the same cycle.
- Latency: the result for a limb is valid in the cycle after its input handshake.
- Throughput: one limb per cycle while res_ready = 1.
- Minimum operation length is 1 (start) + LIMBS (RUN) + 1 (final accept) cycles, then IDLE. The next start is accepted in the following cycle.
- start_ready and in_ready are combinational from state, res_valid and res_ready only. There is no path from in_valid or start_valid.

## Configuration
- CBA_SEQ_ZERO_FLAG_EN defined:
  - A zero accumulator ORs every result limb.
  - res_zero is registered with the last limb: 1 iff all LIMBS result limbs are 0.
  - Cleared on start and on reset.
- CBA_SEQ_ZERO_FLAG_EN undefined: no accumulator logic; res_zero is constant 0.

## Test plan
All scenarios use WIDTH=16, LIMBS=4, limbs listed LSB first.
- Add: A=0x0000_0000_0000_FFFF, B=0x0000_0000_0000_0001 → res_sum 0x0000, 0x0001, 0x0000, 0x0000; res_last on limb 3; res_cout 0, res_ovf 0.
- Subtract: A=0, B=1 → four limbs of 0xFFFF; add_cin = 1 on limb 0; res_cout 0 (borrow), res_ovf 0.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, add → limbs 0x0000 ×3, then 0x8000; res_ovf 1, res_cout 0.
- Backpressure: hold res_ready low for 3 cycles after limb 0 → in_ready 0 and res_sum held 0x0000 throughout; the full sequence completes with no lost or duplicated limbs.
- Reset mid-operation: assert rst after 2 limbs → res_valid 0 next cycle and start_ready 1 after release. A new add of 1+1 gives limb 0 = 0x0002 (carry cleared).
- Zero flag (macro on): A−A with A=0x1234_5678_9ABC_DEF0 → all limbs 0x0000, res_zero 1, res_cout 1. With the macro off, res_zero stays 0.
